time_set_ctrl: RTL and testbench

Front-panel controller for the millennium clock. It generates the 1 Hz count enable that drives the time counters and runs the set-mode state machine that produces `select_item`. It also converts the MODE/UP/DOWN button levels into single-cycle, auto-repeating adjust strobes. It sits between the debounced board buttons and the second/minute/hour/day/month/year counter chain.

---
 rtl/time_set_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel controller for the millennium clock.
// Generates the 1 Hz counter-chain enable and blink phase, steps the set-mode
// field selector on MODE presses, and turns UP/DOWN levels into single-cycle
// auto-repeating adjust strobes.
module time_set_ctrl #(
    parameter int unsigned CLK_HZ     = 1000,
    parameter int unsigned TIMEOUT_S  = 10,
    parameter int unsigned HOLD_CYC   = 500,
    parameter int unsigned REPEAT_CYC = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       en_1,
    output logic [2:0] select_item,
    output logic       up,
    output logic       down,
    output logic       setting,
    output logic       blink
);

    localparam int unsigned PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned IDLE_W   = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam int unsigned HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    // Bit positions inside the sampled button vector
    localparam int unsigned BI_MODE = 2;
    localparam int unsigned BI_UP   = 1;
    localparam int unsigned BI_DN   = 0;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_MIN  = 3'd1,
        ST_HOUR = 3'd2,
        ST_DAY  = 3'd3,
        ST_MON  = 3'd4,
        ST_YEAR = 3'd5
    } state_t;

    logic [PRE_W-1:0]  pre_cnt;
    logic [PRE_W-1:0]  pre_nxt_c;
    logic [2:0]        btn_q;
    logic [2:0]        btn_prev;
    logic [2:0]        rise_c;
    logic              mode_rise_c;
    logic              up_rise_c;
    logic              dn_rise_c;
    logic              any_rise_c;
    logic              both_c;
    logic              timeout_c;
    logic              hold_run_c;
    logic              hold_fire_c;
    state_t            state;
    state_t            adv_c;
    logic [IDLE_W-1:0] idle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rep_phase;
    logic              act_up;
    logic              act_dn;

    // The state register is the field selector itself
    assign select_item = state;

    // Shared decode: prescaler successor, button edges, timeout, repeat timing
    always_comb begin
        pre_nxt_c   = '0;
        rise_c      = '0;
        mode_rise_c = 1'b0;
        up_rise_c   = 1'b0;
        dn_rise_c   = 1'b0;
        any_rise_c  = 1'b0;
        both_c      = 1'b0;
        timeout_c   = 1'b0;
        hold_run_c  = 1'b0;
        hold_fire_c = 1'b0;
        adv_c       = ST_RUN;

        if (pre_cnt != PRE_W'(CLK_HZ - 1)) begin
            pre_nxt_c = pre_cnt + PRE_W'(1);
        end

        rise_c      = btn_q & ~btn_prev;
        mode_rise_c = rise_c[BI_MODE];
        up_rise_c   = rise_c[BI_UP];
        dn_rise_c   = rise_c[BI_DN];
        any_rise_c  = |rise_c;
        both_c      = btn_q[BI_UP] & btn_q[BI_DN];

        // A button edge counts as activity and overrides an expiring timeout
        timeout_c = (state != ST_RUN) && (idle_cnt == IDLE_W'(TIMEOUT_S)) && !any_rise_c;

        hold_run_c  = (act_up && btn_q[BI_UP]) || (act_dn && btn_q[BI_DN]);
        hold_fire_c = rep_phase ? (hold_cnt == HOLD_W'(REPEAT_CYC - 1))
                                : (hold_cnt == HOLD_W'(HOLD_CYC - 1));

        case (state)
            ST_RUN:  adv_c = ST_MIN;
            ST_MIN:  adv_c = ST_HOUR;
            ST_HOUR: adv_c = ST_DAY;
            ST_DAY:  adv_c = ST_MON;
            ST_MON:  adv_c = ST_YEAR;
            default: adv_c = ST_RUN;
        endcase
    end

    // Prescaler with registered 1 Hz enable and blink phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            en_1    <= 1'b0;
            blink   <= 1'b1;
        end else begin
            pre_cnt <= pre_nxt_c;
            en_1    <= (pre_nxt_c == PRE_W'(CLK_HZ - 1));
            blink   <= (pre_nxt_c < PRE_W'(CLK_HZ / 2));
        end
    end

    // Button sampling and previous-value registers for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q    <= '0;
            btn_prev <= '0;
        end else begin
            btn_q    <= {btn_mode, btn_up, btn_down};
            btn_prev <= btn_q;
        end
    end

    // Set-mode FSM: MODE steps through the fields, timeout falls back to RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            setting <= 1'b0;
        end else if (mode_rise_c) begin
            state   <= adv_c;
            setting <= (adv_c != ST_RUN);
        end else if (timeout_c) begin
            state   <= ST_RUN;
            setting <= 1'b0;
        end
    end

    // Idle-seconds counter, counted only while a field is selected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == ST_RUN) || any_rise_c || timeout_c) begin
            idle_cnt <= '0;
        end else if (en_1 && (idle_cnt != IDLE_W'(TIMEOUT_S))) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Adjust strobes: one on the press, then hold delay, then fixed-rate repeat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up        <= 1'b0;
            down      <= 1'b0;
            act_up    <= 1'b0;
            act_dn    <= 1'b0;
            rep_phase <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            if ((state == ST_RUN) || mode_rise_c || timeout_c || both_c) begin
                // A held button must be released and pressed again after this
                act_up    <= 1'b0;
                act_dn    <= 1'b0;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end else if (up_rise_c) begin
                up        <= 1'b1;
                act_up    <= 1'b1;
                act_dn    <= 1'b0;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end else if (dn_rise_c) begin
                down      <= 1'b1;
                act_up    <= 1'b0;
                act_dn    <= 1'b1;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end else if (hold_run_c) begin
                if (hold_fire_c) begin
                    up        <= act_up;
                    down      <= act_dn;
                    rep_phase <= 1'b1;
                    hold_cnt  <= '0;
                end else begin
                    hold_cnt  <= hold_cnt + HOLD_W'(1);
                end
            end else begin
                act_up    <= 1'b0;
                act_dn    <= 1'b0;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl with small parameters.
// Expected select/strobe events are queued as stimulus is driven and matched
// against what the DUT emits; en_1, blink and setting are checked every cycle.
module tb_time_set_ctrl;

    localparam int unsigned CLK_HZ     = 10;
    localparam int unsigned TIMEOUT_S  = 3;
    localparam int unsigned HOLD_CYC   = 8;
    localparam int unsigned REPEAT_CYC = 4;
    localparam int          HZ         = 10;

    localparam int EV_SEL = 0;
    localparam int EV_UP  = 1;
    localparam int EV_DN  = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       en_1;
    logic [2:0] select_item;
    logic       up;
    logic       down;
    logic       setting;
    logic       blink;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc       = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  r_cyc     = 0;
    int  model_sel = 0;
    int  last_sel  = 0;
    bit  armed     = 1'b0;
    bit  rst_edge  = 1'b0;

    time_set_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_S  (TIMEOUT_S),
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .en_1        (en_1),
        .select_item (select_item),
        .up          (up),
        .down        (down),
        .setting     (setting),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge n, cyc == n
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rst_n;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic got_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_val", val, e.val);
            check("event_cycle", cyc, e.cyc);
            if (e.kind == EV_SEL) model_sel = e.val;
        end
    endtask

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_edge) begin
            r_cyc     = cyc;
            model_sel = 0;
            last_sel  = 0;
            armed     = 1'b1;
            check("rst_en_1", int'(en_1), 0);
            check("rst_select", int'(select_item), 0);
            check("rst_up", int'(up), 0);
            check("rst_down", int'(down), 0);
            check("rst_setting", int'(setting), 0);
            check("rst_blink", int'(blink), 1);
        end else if (armed) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_event_kind", -1, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            check("en_1", int'(en_1), int'(((cyc - r_cyc) % HZ) == HZ - 1));
            check("blink", int'(blink), int'(((cyc - r_cyc) % HZ) < HZ / 2));
            if (int'(select_item) != last_sel) begin
                last_sel = int'(select_item);
                got_ev(EV_SEL, last_sel);
            end
            if (up)   got_ev(EV_UP, 0);
            if (down) got_ev(EV_DN, 0);
            check("setting", int'(setting), int'(model_sel != 0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int val, input int c);
        exp_q.push_back('{kind: kind, val: val, cyc: c});
    endtask

    // One-cycle MODE press; the new field shows two edges later
    task automatic press_mode(input int v);
        tick();
        btn_mode = 1'b1;
        push(EV_SEL, v, cyc + 2);
        tick();
        btn_mode = 1'b0;
    endtask

    function automatic int next_en(input int c);
        int e;
        e = c;
        while (((e - r_cyc) % HZ) != HZ - 1) e++;
        return e;
    endfunction

    initial begin
        int p;
        int m;
        int e1;
        int e2;
        int e3;
        int x;

        // Reset and free-run
        tick();
        tick();
        rst_n = 1'b1;
        repeat (35) tick();

        // MODE cycles through every field and back to RUN
        for (int i = 1; i <= 6; i++) press_mode(i % 6);
        repeat (4) tick();

        // HOUR: hold UP for 20 cycles, expect press strobe then repeats
        press_mode(1);
        press_mode(2);
        tick();
        btn_up = 1'b1;
        p = cyc;
        push(EV_UP, 0, p + 2);
        push(EV_UP, 0, p + 2 + int'(HOLD_CYC));
        push(EV_UP, 0, p + 2 + int'(HOLD_CYC) + int'(REPEAT_CYC));
        push(EV_UP, 0, p + 2 + int'(HOLD_CYC) + 2 * int'(REPEAT_CYC));
        while (cyc < p + 20) tick();
        btn_up = 1'b0;
        press_mode(3);
        press_mode(4);
        press_mode(5);
        press_mode(0);
        repeat (4) tick();

        // MIN idle: auto-exit after the third en_1
        press_mode(1);
        m  = cyc + 1;
        e1 = next_en(m);
        e2 = next_en(e1 + 1);
        e3 = next_en(e2 + 1);
        push(EV_SEL, 0, e3 + 2);
        while (cyc < e3 + 4) tick();

        // MIN with a DOWN press on the second en_1 restarts the timeout
        press_mode(1);
        m  = cyc + 1;
        e1 = next_en(m);
        e2 = next_en(e1 + 1);
        while (cyc < e2) tick();
        btn_down = 1'b1;
        push(EV_DN, 0, e2 + 2);
        tick();
        btn_down = 1'b0;
        x  = e2 + 2;
        e1 = next_en(x);
        e2 = next_en(e1 + 1);
        e3 = next_en(e2 + 1);
        push(EV_SEL, 0, e3 + 2);
        while (cyc < e3 + 4) tick();

        // DAY: UP and DOWN together give nothing, survivor needs a new press
        press_mode(1);
        press_mode(2);
        press_mode(3);
        tick();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        repeat (8) tick();
        btn_down = 1'b0;
        repeat (10) tick();
        btn_up = 1'b0;
        tick();
        btn_up = 1'b1;
        push(EV_UP, 0, cyc + 2);
        tick();
        btn_up = 1'b0;
        press_mode(4);
        press_mode(5);
        press_mode(0);
        repeat (4) tick();

        // YEAR with UP held: reset on the edge a repeat was due
        for (int i = 1; i <= 5; i++) press_mode(i);
        tick();
        btn_up = 1'b1;
        p = cyc;
        push(EV_UP, 0, p + 2);
        while (cyc < p + 9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        btn_up = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
